// File: rtl/palette_scheduler.sv
// -----------------------------------------------------------------------------
// palette_scheduler
//
// Per-frame sequencer for the serial character-matrix LED path. On each frame
// request it walks pixels 0..NUM_PIXELS-1 in order. For each pixel it:
//   * computes a palette ROM address from the latched mode, the pixel index and
//     a scrolling offset,
//   * masks the ROM colour with the character generator's on/off bit, and
//   * hands the colour to the LED serialiser over a valid/ready handshake.
// The scroll offset advances once every FRAMES_PER_STEP completed frames, which
// produces the rainbow scroll.
//
// Ports:
//   clk          in   system clock; all state changes on the rising edge
//   rst          in   asynchronous active-high reset
//   frame_start  in   one-cycle frame request; honoured only while idle
//   mode         in   0 scroll, 1 fixed, 2 flat-cycle, 3 reserved (acts as 0)
//   color_sel    in   palette entry used in fixed mode
//   rom_addr     out  palette ROM address (combinational)
//   rom_data     in   palette ROM colour, combinational from rom_addr (GRB)
//   pixel_index  out  index of the pixel being fetched or presented
//   pixel_on     in   character-generator bit for pixel_index (combinational)
//   pixel_valid  out  pixel_color is valid
//   pixel_ready  in   serialiser accepts the pixel
//   pixel_color  out  masked colour
//   frame_done   out  one-cycle pulse after the last pixel handshake
//   busy         out  high whenever the sequencer is not idle
//
// Handshake: a pixel transfers on a rising edge where pixel_valid and
// pixel_ready are both high. Once pixel_valid is raised, pixel_valid,
// pixel_color and pixel_index hold their values until that transfer; the
// serialiser may hold pixel_ready low for any number of cycles.
// -----------------------------------------------------------------------------
module palette_scheduler #(
    parameter int NUM_PIXELS      = 40,
    parameter int PIX_WIDTH       = 6,
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 24,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] color_sel,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [PIX_WIDTH-1:0]  pixel_index,
    input  logic                  pixel_on,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic [DATA_WIDTH-1:0] pixel_color,
    output logic                  frame_done,
    output logic                  busy
);

    // Frame counter wide enough to hold FRAMES_PER_STEP-1 (at least one bit).
    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [PIX_WIDTH-1:0] LAST_PIX   = PIX_WIDTH'(NUM_PIXELS - 1);
    localparam logic [FCW-1:0]       LAST_FRAME = FCW'(FRAMES_PER_STEP - 1);

    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_FLAT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q,       state_d;
    logic [PIX_WIDTH-1:0]    pix_idx_q,     pix_idx_d;
    logic [ADDR_WIDTH-1:0]   offset_q,      offset_d;
    logic [FCW-1:0]          frame_cnt_q,   frame_cnt_d;
    logic [1:0]              mode_q,        mode_d;
    logic [ADDR_WIDTH-1:0]   color_sel_q,   color_sel_d;
    logic                    valid_q,       valid_d;
    logic [DATA_WIDTH-1:0]   color_q,       color_d;
    logic                    done_q,        done_d;
    logic                    busy_q,        busy_d;

    // -------------------------------------------------------------------------
    // Palette address. Only meaningful during FETCH, but driven from the same
    // function in every state so the ROM sees a steady, glitch-free address.
    // All additions wrap modulo the ROM size (carry dropped). Mode 3 falls into
    // the scroll branch.
    // -------------------------------------------------------------------------
    always_comb begin
        rom_addr = pix_idx_q[ADDR_WIDTH-1:0] + offset_q;
        case (mode_q)
            MODE_FIXED: rom_addr = color_sel_q;
            MODE_FLAT:  rom_addr = offset_q;
            default:    rom_addr = pix_idx_q[ADDR_WIDTH-1:0] + offset_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pix_idx_d   = pix_idx_q;
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        color_sel_d = color_sel_q;
        valid_d     = valid_q;
        color_d     = color_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Mode and colour select are captured here so the whole frame
                // uses one consistent setting, whatever the inputs do later.
                if (frame_start) begin
                    mode_d      = mode;
                    color_sel_d = color_sel;
                    pix_idx_d   = '0;
                    state_d     = FETCH;
                end
            end

            FETCH: begin
                color_d = pixel_on ? rom_data : '0;
                valid_d = 1'b1;
                state_d = PRESENT;
            end

            PRESENT: begin
                if (valid_q && pixel_ready) begin
                    valid_d = 1'b0;
                    if (pix_idx_q == LAST_PIX) begin
                        // Raise frame_done for exactly the DONE cycle.
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        pix_idx_d = pix_idx_q + PIX_WIDTH'(1);
                        state_d   = FETCH;
                    end
                end
            end

            DONE: begin
                // The offset only moves here, so it is constant for a frame.
                if (frame_cnt_q == LAST_FRAME) begin
                    frame_cnt_d = '0;
                    offset_d    = offset_q + ADDR_WIDTH'(1);
                end else begin
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered busy tracks the state it will be in next cycle.
        busy_d = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers. Reset aborts any frame in flight: no frame_done, and the
    // offset and frame counter restart from zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_idx_q   <= '0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            color_sel_q <= '0;
            valid_q     <= 1'b0;
            color_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_idx_q   <= pix_idx_d;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            color_sel_q <= color_sel_d;
            valid_q     <= valid_d;
            color_q     <= color_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign pixel_index = pix_idx_q;
    assign pixel_valid = valid_q;
    assign pixel_color = color_q;
    assign frame_done  = done_q;
    assign busy        = busy_q;

endmodule

// File: doc/palette_scheduler.md
Name: palette_scheduler

Overview:
- Per-frame sequencer for the 16-entry, 24-bit palette ROM (combinational read, GRB order) in the serial character-matrix LED path.
- On each frame request it walks every pixel of the matrix in order and computes the palette address from the mode, pixel index and a scrolling offset.
- It masks the colour with the pixel's on/off bit from the character generator and hands each colour to the LED serialiser over a valid/ready handshake.
- It advances the scroll offset every FRAMES_PER_STEP completed frames, giving a rainbow scroll.

Parameters:
- NUM_PIXELS, 40, number of pixels per frame (indices 0..NUM_PIXELS-1).
- PIX_WIDTH, 6, width of pixel index; must satisfy 2**PIX_WIDTH >= NUM_PIXELS.
- ADDR_WIDTH, 4, palette ROM address width (16 entries).
- DATA_WIDTH, 24, palette colour width.
- FRAMES_PER_STEP, 4, completed frames per offset increment; valid range 1..256.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- frame_start, input, 1, one-cycle request to emit a frame.
- mode, input, 2, 0 = scroll, 1 = fixed, 2 = flat-cycle, 3 = reserved (treated as 0).
- color_sel, input, ADDR_WIDTH, palette entry used in fixed mode.
- rom_addr, output, ADDR_WIDTH, palette ROM address.
- rom_data, input, DATA_WIDTH, palette ROM data (combinational from rom_addr).
- pixel_index, output, PIX_WIDTH, index of pixel being fetched or presented.
- pixel_on, input, 1, character-generator bit for pixel_index (combinational).
- pixel_valid, output, 1, pixel_color valid.
- pixel_ready, input, 1, serialiser accepts pixel.
- pixel_color, output, DATA_WIDTH, masked colour.
- frame_done, output, 1, one-cycle pulse after the last pixel handshake.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE; pixel_index = 0; offset = 0; frame_cnt = 0.
  - pixel_valid = 0; pixel_color = 0; frame_done = 0; busy = 0.
  - Latched mode and latched color_sel = 0.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued and the offset is not advanced.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - On frame_start = 1: latch mode and color_sel, clear pixel_index, go to FETCH.
  - frame_start in any other state is ignored, not queued.
- FETCH (1 cycle):
  - rom_addr is driven combinationally per the latched mode.
  - Register pixel_color = pixel_on ? rom_data : 0 and set pixel_valid = 1. Go to PRESENT.
- PRESENT:
  - pixel_valid and pixel_color are held stable until pixel_ready = 1.
  - On handshake (valid & ready), clear pixel_valid.
  - If pixel_index == NUM_PIXELS-1, go to DONE. Otherwise increment pixel_index and go to FETCH.
  - Consequence: one pixel per 2 cycles at most; pixel_valid deasserts for the FETCH cycle between pixels.
- DONE (1 cycle):
  - frame_done = 1.
  - If frame_cnt == FRAMES_PER_STEP-1: frame_cnt = 0 and offset = offset+1 (mod 16, 15 wraps to 0). Otherwise frame_cnt++.
  - Go to IDLE.
- Address rules (all arithmetic mod 2**ADDR_WIDTH, carry discarded):
  - mode 0/3: rom_addr = pixel_index[ADDR_WIDTH-1:0] + offset.
  - mode 1: rom_addr = latched color_sel.
  - mode 2: rom_addr = offset.
  - Outside FETCH, rom_addr is still driven by the same function; its value is don't-care for checking.
- Latency: frame_start at edge N means state = FETCH after edge N, and first pixel_valid = 1 after edge N+1.
- Offset is stable for the whole frame. It changes only in DONE.
- busy = 1 from the edge after frame_start through the DONE cycle inclusive.

Test Plan:
- Reset, mode 0, offset 0, pixel_ready tied 1, pixel_on all 1, frame_start:
  - pixel 0 colour = 24'h00CC00 (entry 0), pixel 1 = 24'h4CCC00, pixel 15 = 24'h00CC4C, pixel 16 = 24'h00CC00 (wrap).
  - Exactly 40 handshakes, frame_done one cycle after the 40th, total 81 cycles from frame_start to frame_done.
- Offset advance: 4 frames in mode 0, then frame 5 → pixel 0 = entry 1 = 24'h4CCC00. After 64 frames the offset is back to 0 → pixel 0 = 24'h00CC00.
- Backpressure: pixel_ready held 0 for 5 cycles on pixel 3 → pixel_valid and pixel_color stable all 5 cycles. pixel_index stays 3 and advances only after ready = 1.
- Masking and fixed mode: mode 1, color_sel = 6, pixel_on alternating 1/0 → colours alternate 24'hCC0033 / 24'h000000. Changing color_sel mid-frame has no effect.
- Ignored request and async reset:
  - frame_start pulsed mid-frame → no extra frame, only 40 handshakes.
  - rst asserted asynchronously at pixel 20 → pixel_valid, busy and frame_done drop immediately, offset = 0.
  - The next frame_start restarts at pixel 0.
